msk_rnd_prng: RTL and testbench

MSK_RND_PRNG -- requirements
Module: msk_rnd_prng

---
 rtl/msk_rnd_prng.sv | 60 ++++++
 tb/tb_msk_rnd_prng.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_rnd_prng.sv
// msk_rnd_prng: 128-bit LFSR randomness source for masked HPC2 gadgets with seeding, warm-up and reseed budget
module msk_rnd_prng #(
   parameter int d = 2,
   parameter int NGADGETS = 5,
   parameter int WARMUP = 16,
   parameter int RESEED_PERIOD = 65536,
   localparam int RW = NGADGETS * d * (d - 1) / 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [127:0]  seed,
   input  logic          seed_valid,
   output logic          seed_ready,
   output logic [RW-1:0] rnd,
   output logic          rnd_valid,
   input  logic          rnd_ready,
   output logic          reseed_req
);
   localparam logic [1:0] UNSEEDED = 2'd0, WARM = 2'd1, RUN = 2'd2, STARVED = 2'd3;
   logic [1:0] st;
   logic [127:0] s, adv;
   logic [31:0] tcnt, wcnt;
   logic load;
   if (RW > 128 || RW < 1) begin : g_rw_check
      $error("msk_rnd_prng: RW must be in 1..128");
   end
   always_comb begin
      adv = s;
      for (int i = 0; i < RW; i++) adv = {adv[126:0], adv[127] ^ adv[28] ^ adv[26] ^ adv[1]};
   end
   assign seed_ready = st != WARM;
   assign rnd_valid  = st == RUN;
   assign reseed_req = st == STARVED;
   assign rnd        = s[RW-1:0];
   assign load       = seed_valid & seed_ready;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st   <= UNSEEDED;
         s    <= '0;
         tcnt <= '0;
         wcnt <= '0;
      end else if (load) begin
         st   <= WARM;
         s    <= (seed == '0) ? 128'h1 : seed;
         tcnt <= '0;
         wcnt <= '0;
      end else if (st == WARM) begin
         if (WARMUP == 0) st <= RUN;
         else begin
            s    <= adv;
            wcnt <= wcnt + 32'd1;
            if (wcnt == 32'(WARMUP - 1)) st <= RUN;
         end
      end else if (st == RUN && rnd_ready) begin
         s    <= adv;
         tcnt <= tcnt + 32'd1;
         if (RESEED_PERIOD != 0 && tcnt + 32'd1 == 32'(RESEED_PERIOD)) st <= STARVED;
      end
   end
endmodule

// File: tb/tb_msk_rnd_prng.sv
// tb_msk_rnd_prng: scoreboard bench for msk_rnd_prng with a warm-up-free and a 16-cycle warm-up instance
module tb_msk_rnd_prng;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;
   logic [127:0] seed;
   logic seed_valid [2];
   logic rnd_ready [2];
   logic seed_ready [2];
   logic rnd_valid [2];
   logic reseed_req [2];
   logic [4:0] rnd [2];
   int pass_cnt = 0;
   int tot = 0;
   logic [127:0] m [2];
   logic [4:0] exp_q [$];
   logic [4:0] e;

   msk_rnd_prng #(.d(2), .NGADGETS(5), .WARMUP(0), .RESEED_PERIOD(4)) u0 (
      .clk(clk), .rst_n(rst_n), .seed(seed), .seed_valid(seed_valid[0]), .seed_ready(seed_ready[0]),
      .rnd(rnd[0]), .rnd_valid(rnd_valid[0]), .rnd_ready(rnd_ready[0]), .reseed_req(reseed_req[0]));
   msk_rnd_prng #(.d(2), .NGADGETS(5), .WARMUP(16), .RESEED_PERIOD(4)) u1 (
      .clk(clk), .rst_n(rst_n), .seed(seed), .seed_valid(seed_valid[1]), .seed_ready(seed_ready[1]),
      .rnd(rnd[1]), .rnd_valid(rnd_valid[1]), .rnd_ready(rnd_ready[1]), .reseed_req(reseed_req[1]));

   function automatic logic [127:0] lfsr(input logic [127:0] x, input int n);
      logic [127:0] y;
      y = x;
      for (int i = 0; i < n; i++) y = {y[126:0], y[127] ^ y[28] ^ y[26] ^ y[1]};
      return y;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int k, input logic [127:0] sd);
      seed = sd;
      seed_valid[k] = 1'b1;
      tick();
      seed_valid[k] = 1'b0;
      m[k] = (sd == '0) ? 128'h1 : sd;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      seed = '0;
      for (int k = 0; k < 2; k++) begin
         seed_valid[k] = 1'b0;
         rnd_ready[k] = 1'b0;
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tot++; if (seed_ready[k] !== 1'b1) $display("FAIL reset_seed_ready[%0d]: got %b want 1", k, seed_ready[k]); else pass_cnt++;
         tot++; if (rnd_valid[k] !== 1'b0) $display("FAIL reset_rnd_valid[%0d]: got %b want 0", k, rnd_valid[k]); else pass_cnt++;
         tot++; if (reseed_req[k] !== 1'b0) $display("FAIL reset_reseed_req[%0d]: got %b want 0", k, reseed_req[k]); else pass_cnt++;
         tot++; if (rnd[k] !== 5'd0) $display("FAIL reset_rnd[%0d]: got %h want 0", k, rnd[k]); else pass_cnt++;
      end
   endtask

   task automatic test_warm0();
      load(0, 128'h1);
      tot++; if (rnd_valid[0] !== 1'b0) $display("FAIL warm0_valid_warm: got %b want 0", rnd_valid[0]); else pass_cnt++;
      tot++; if (seed_ready[0] !== 1'b0) $display("FAIL warm0_seed_ready_warm: got %b want 0", seed_ready[0]); else pass_cnt++;
      tick();
      tot++; if (rnd_valid[0] !== 1'b1) $display("FAIL warm0_valid_run: got %b want 1", rnd_valid[0]); else pass_cnt++;
      exp_q.push_back(m[0][4:0]);
      e = exp_q.pop_front();
      tot++; if (rnd[0] !== e) $display("FAIL warm0_first_rnd: got %h want %h", rnd[0], e); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         rnd_ready[0] = 1'b1;
         tick();
         m[0] = lfsr(m[0], 5);
         exp_q.push_back(m[0][4:0]);
         e = exp_q.pop_front();
         tot++; if (rnd[0] !== e) $display("FAIL warm0_xfer%0d: got %h want %h", i, rnd[0], e); else pass_cnt++;
      end
      rnd_ready[0] = 1'b0;
   endtask

   task automatic test_zero_seed();
      load(0, 128'h0);
      tick();
      tot++; if (rnd_valid[0] !== 1'b1) $display("FAIL zero_valid: got %b want 1", rnd_valid[0]); else pass_cnt++;
      m[0] = 128'h1;
      exp_q.push_back(m[0][4:0]);
      e = exp_q.pop_front();
      tot++; if (rnd[0] !== e) $display("FAIL zero_first_rnd: got %h want %h", rnd[0], e); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         rnd_ready[0] = 1'b1;
         tick();
         m[0] = lfsr(m[0], 5);
         exp_q.push_back(m[0][4:0]);
         e = exp_q.pop_front();
         tot++; if (rnd[0] !== e) $display("FAIL zero_xfer%0d: got %h want %h", i, rnd[0], e); else pass_cnt++;
      end
      rnd_ready[0] = 1'b0;
   endtask

   task automatic test_reseed_period();
      int xfers;
      logic [127:0] sd2;
      load(0, rand128());
      tick();
      tot++; if (rnd_valid[0] !== 1'b1) $display("FAIL period_valid: got %b want 1", rnd_valid[0]); else pass_cnt++;
      exp_q.push_back(m[0][4:0]);
      rnd_ready[0] = 1'b1;
      xfers = 0;
      for (int i = 0; i < 10 && rnd_valid[0]; i++) begin
         e = exp_q.pop_front();
         tot++; if (rnd[0] !== e) $display("FAIL period_rnd%0d: got %h want %h", i, rnd[0], e); else pass_cnt++;
         tick();
         xfers++;
         m[0] = lfsr(m[0], 5);
         exp_q.push_back(m[0][4:0]);
      end
      tot++; if (xfers !== 4) $display("FAIL period_xfers: got %0d want 4", xfers); else pass_cnt++;
      tot++; if (reseed_req[0] !== 1'b1) $display("FAIL period_reseed_req: got %b want 1", reseed_req[0]); else pass_cnt++;
      tot++; if (seed_ready[0] !== 1'b1) $display("FAIL period_seed_ready: got %b want 1", seed_ready[0]); else pass_cnt++;
      e = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
         tot++; if (rnd[0] !== e) $display("FAIL starved_frozen%0d: got %h want %h", i, rnd[0], e); else pass_cnt++;
         tot++; if (rnd_valid[0] !== 1'b0) $display("FAIL starved_valid%0d: got %b want 0", i, rnd_valid[0]); else pass_cnt++;
         tick();
      end
      rnd_ready[0] = 1'b0;
      sd2 = rand128();
      load(0, sd2);
      tot++; if (reseed_req[0] !== 1'b0) $display("FAIL reseed_clear_req: got %b want 0", reseed_req[0]); else pass_cnt++;
      tot++; if (rnd_valid[0] !== 1'b0) $display("FAIL reseed_warm_valid: got %b want 0", rnd_valid[0]); else pass_cnt++;
      exp_q.push_back(m[0][4:0]);
      e = exp_q.pop_front();
      tot++; if (rnd[0] !== e) $display("FAIL reseed_loaded_rnd: got %h want %h", rnd[0], e); else pass_cnt++;
      tick();
      tot++; if (rnd_valid[0] !== 1'b1) $display("FAIL reseed_run_valid: got %b want 1", rnd_valid[0]); else pass_cnt++;
   endtask

   task automatic test_warmup16();
      int n;
      load(1, rand128());
      tot++; if (seed_ready[1] !== 1'b0) $display("FAIL warm16_seed_ready: got %b want 0", seed_ready[1]); else pass_cnt++;
      n = 1;
      while (!rnd_valid[1] && n < 40) begin
         tick();
         n++;
      end
      tot++; if (n !== 17) $display("FAIL warm16_latency: got %0d want 17", n); else pass_cnt++;
      m[1] = lfsr(m[1], 16 * 5);
      exp_q.push_back(m[1][4:0]);
      e = exp_q.pop_front();
      tot++; if (rnd[1] !== e) $display("FAIL warm16_first_rnd: got %h want %h", rnd[1], e); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [7:0] pat;
      pat = 8'b01001010;
      for (int i = 0; i < 8; i++) begin
         rnd_ready[1] = pat[i];
         tick();
         if (pat[i]) m[1] = lfsr(m[1], 5);
         exp_q.push_back(m[1][4:0]);
         e = exp_q.pop_front();
         tot++; if (rnd[1] !== e) $display("FAIL bp_rnd%0d: got %h want %h", i, rnd[1], e); else pass_cnt++;
         tot++; if (rnd_valid[1] !== 1'b1) $display("FAIL bp_valid%0d: got %b want 1", i, rnd_valid[1]); else pass_cnt++;
      end
      rnd_ready[1] = 1'b0;
   endtask

   task automatic test_reseed_priority();
      int n;
      int xfers;
      logic [127:0] sd;
      sd = rand128();
      seed = sd;
      seed_valid[1] = 1'b1;
      rnd_ready[1] = 1'b1;
      tick();
      seed_valid[1] = 1'b0;
      rnd_ready[1] = 1'b0;
      m[1] = (sd == '0) ? 128'h1 : sd;
      tot++; if (rnd_valid[1] !== 1'b0) $display("FAIL prio_valid: got %b want 0", rnd_valid[1]); else pass_cnt++;
      tot++; if (seed_ready[1] !== 1'b0) $display("FAIL prio_seed_ready: got %b want 0", seed_ready[1]); else pass_cnt++;
      exp_q.push_back(m[1][4:0]);
      e = exp_q.pop_front();
      tot++; if (rnd[1] !== e) $display("FAIL prio_loaded_rnd: got %h want %h", rnd[1], e); else pass_cnt++;
      n = 1;
      while (!rnd_valid[1] && n < 40) begin
         tick();
         n++;
      end
      tot++; if (n !== 17) $display("FAIL prio_warm_latency: got %0d want 17", n); else pass_cnt++;
      m[1] = lfsr(m[1], 16 * 5);
      exp_q.push_back(m[1][4:0]);
      e = exp_q.pop_front();
      tot++; if (rnd[1] !== e) $display("FAIL prio_first_rnd: got %h want %h", rnd[1], e); else pass_cnt++;
      rnd_ready[1] = 1'b1;
      xfers = 0;
      for (int i = 0; i < 10 && rnd_valid[1]; i++) begin
         tick();
         xfers++;
      end
      rnd_ready[1] = 1'b0;
      tot++; if (xfers !== 4) $display("FAIL prio_budget: got %0d want 4", xfers); else pass_cnt++;
      tot++; if (reseed_req[1] !== 1'b1) $display("FAIL prio_reseed_req: got %b want 1", reseed_req[1]); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      load(1, rand128());
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tot++; if (seed_ready[1] !== 1'b1) $display("FAIL rstwarm_seed_ready: got %b want 1", seed_ready[1]); else pass_cnt++;
      tot++; if (rnd_valid[1] !== 1'b0) $display("FAIL rstwarm_valid: got %b want 0", rnd_valid[1]); else pass_cnt++;
      tot++; if (reseed_req[1] !== 1'b0) $display("FAIL rstwarm_reseed_req: got %b want 0", reseed_req[1]); else pass_cnt++;
      tot++; if (rnd[1] !== 5'd0) $display("FAIL rstwarm_rnd: got %h want 0", rnd[1]); else pass_cnt++;
      for (int i = 0; i < 20; i++) tick();
      tot++; if (rnd_valid[1] !== 1'b0) $display("FAIL rstwarm_stays_unseeded: got %b want 0", rnd_valid[1]); else pass_cnt++;
      load(0, rand128());
      tick();
      tot++; if (rnd_valid[0] !== 1'b1) $display("FAIL rstrun_pre_valid: got %b want 1", rnd_valid[0]); else pass_cnt++;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tot++; if (rnd_valid[0] !== 1'b0) $display("FAIL rstrun_valid: got %b want 0", rnd_valid[0]); else pass_cnt++;
      tot++; if (seed_ready[0] !== 1'b1) $display("FAIL rstrun_seed_ready: got %b want 1", seed_ready[0]); else pass_cnt++;
      tot++; if (rnd[0] !== 5'd0) $display("FAIL rstrun_rnd: got %h want 0", rnd[0]); else pass_cnt++;
      for (int i = 0; i < 3; i++) tick();
      tot++; if (rnd_valid[0] !== 1'b0) $display("FAIL rstrun_stays_unseeded: got %b want 0", rnd_valid[0]); else pass_cnt++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_warm0();
      test_zero_seed();
      test_reseed_period();
      test_warmup16();
      test_backpressure();
      test_reseed_priority();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, tot);
      $finish;
   end
endmodule
